// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: load-use and branch-operand interlocks over
// NBACK back-end stages, mul/div hold FSM, ID re-decode flag, stall counter.
module pipe_hazard_ctrl #(
  parameter int NBACK = 3,
  parameter int REGW  = 5,
  parameter int CNTW  = 16,
  localparam int NPR  = NBACK + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    id_valid,
  input  logic                    id_branch,
  input  logic                    id_rs_ren,
  input  logic                    id_rt_ren,
  input  logic [REGW-1:0]         id_rs,
  input  logic [REGW-1:0]         id_rt,
  input  logic                    ex_rs_ren,
  input  logic                    ex_rt_ren,
  input  logic [REGW-1:0]         ex_rs,
  input  logic [REGW-1:0]         ex_rt,
  input  logic                    ex_md_start,
  input  logic                    md_done,
  input  logic [NBACK-1:0]        stg_regwen,
  input  logic [NBACK*REGW-1:0]   stg_wreg,
  input  logic [NBACK-1:0]        stg_ready,
  input  logic                    exc_oc,
  input  logic                    perf_clr,
  output logic [NPR-1:0]          stall,
  output logic [NPR-1:0]          refresh,
  output logic                    id_recode,
  output logic                    md_busy,
  output logic                    md_cancel,
  output logic [CNTW-1:0]         stall_cnt
);

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

  md_state_e        md_state;
  logic [NBACK-1:0] eff_ready;
  logic             ex_haz;
  logic             br_haz;
  logic             md_start;
  logic             md_hold;

  // Scanning oldest to youngest lets the youngest match overwrite older ones.
  function automatic logic src_haz(
    input logic [REGW-1:0]       src,
    input int                    first,
    input logic [NBACK-1:0]      regwen,
    input logic [NBACK*REGW-1:0] wreg,
    input logic [NBACK-1:0]      ready
  );
    logic haz;
    haz = 1'b0;
    for (int k = NBACK - 1; k >= first; k--) begin
      if (regwen[k] && (wreg[k*REGW +: REGW] == src)) haz = !ready[k];
    end
    return haz && (src != '0);
  endfunction

  // The oldest stage is writing back, so its result is always available.
  assign eff_ready = stg_ready | {1'b1, {(NBACK-1){1'b0}}};

  always_comb begin
    ex_haz = (ex_rs_ren && src_haz(ex_rs, 1, stg_regwen, stg_wreg, eff_ready)) ||
             (ex_rt_ren && src_haz(ex_rt, 1, stg_regwen, stg_wreg, eff_ready));
    br_haz = id_valid && id_branch && !ex_haz &&
             ((id_rs_ren && src_haz(id_rs, 0, stg_regwen, stg_wreg, eff_ready)) ||
              (id_rt_ren && src_haz(id_rt, 0, stg_regwen, stg_wreg, eff_ready)));
  end

  assign md_start  = (md_state == MD_IDLE) && ex_md_start && !ex_haz && !exc_oc;
  assign md_hold   = md_start || ((md_state == MD_BUSY) && !md_done && !exc_oc);
  assign md_busy   = (md_state == MD_BUSY);
  assign md_cancel = (md_state == MD_BUSY) && exc_oc && !reset;

  // NOTE: every output gets a default before the priority chain so no path
  // leaves a bit unassigned, which would otherwise infer a latch.
  always_comb begin
    stall   = '0;
    refresh = '0;
    if (exc_oc) begin
      refresh = {1'b0, {(NPR-1){1'b1}}};
    end else if (ex_haz || md_hold) begin
      stall[0]   = 1'b1;
      stall[1]   = 1'b1;
      refresh[2] = 1'b1;
    end else if (br_haz) begin
      stall[0]   = 1'b1;
      refresh[1] = 1'b1;
    end else begin
      refresh[1] = !id_valid;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_state  <= MD_IDLE;
      id_recode <= 1'b0;
      stall_cnt <= '0;
    end else begin
      case (md_state)
        MD_IDLE: if (md_start) md_state <= MD_BUSY;
        MD_BUSY: if (md_done || exc_oc) md_state <= MD_IDLE;
        default: md_state <= MD_IDLE;
      endcase
      id_recode <= !exc_oc && (ex_haz || md_hold || br_haz);
      if (perf_clr)
        stall_cnt <= '0;
      else if (stall[0] && (stall_cnt != {CNTW{1'b1}}))
        stall_cnt <= stall_cnt + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

endmodule
